// File: rtl/cpu_csr_unit_if.sv
// CSR access bus between the writeback stage and the machine-mode CSR unit.
// The pipeline drives addresses and the write operation; the unit returns read data and the illegal flag.
interface cpu_csr_unit_if;
  logic [11:0] raddr;
  logic [31:0] rdata;
  logic [1:0]  csr_op;
  logic [11:0] waddr;
  logic [31:0] wsrc;
  logic        wenable;
  logic        illegal_access;

  modport master (
    output raddr, csr_op, waddr, wsrc, wenable,
    input  rdata, illegal_access
  );

  modport slave (
    input  raddr, csr_op, waddr, wsrc, wenable,
    output rdata, illegal_access
  );
endinterface

// File: rtl/cpu_csr_unit.sv
// Machine-mode CSR unit for the RV32 pipeline: trap and interrupt state, mret, counters and HPM counters.
// Reads are combinational from current state; all updates land on the next rising clock edge.
module cpu_csr_unit #(
  parameter int NUM_HPM  = 4,
  parameter int CNT_W    = 64,
  parameter int VECTORED = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  cpu_csr_unit_if.slave                          csr,
  input  logic                                   retire_w,
  input  logic                                   exception_w,
  input  logic [3:0]                             exc_cause_w,
  input  logic                                   irq_accept_w,
  input  logic                                   mret_w,
  input  logic [31:0]                            pc_w,
  input  logic                                   irq_ext,
  input  logic                                   irq_timer,
  input  logic                                   irq_sw,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event,
  output logic                                   irq_pending,
  output logic [31:0]                            trap_vector,
  output logic [31:0]                            mepc,
  output logic [1:0]                             priv
);

  localparam int HPM_N = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [1:0] PRIV_U = 2'b00;

  logic [1:0]       priv_r;
  logic             mst_mie_r;
  logic             mst_mpie_r;
  logic [1:0]       mst_mpp_r;
  logic [31:0]      mie_r;
  logic [31:0]      mtvec_r;
  logic [31:0]      mscratch_r;
  logic [31:0]      mepc_r;
  logic [31:0]      mcause_r;
  logic [2:0]       irq_s1_r;
  logic [2:0]       irq_s2_r;
  logic [CNT_W-1:0] mcycle_r;
  logic [CNT_W-1:0] minstret_r;
  logic [CNT_W-1:0] hpm_cnt_r [HPM_N];

  logic [31:0] mstatus_s;
  logic [31:0] mip_s;
  logic [31:0] pend_s;
  logic        gie_s;
  logic        irq_pending_s;
  logic [3:0]  irq_code_s;
  logic [32:0] rlook_s;
  logic [32:0] wlook_s;
  logic        wro_s;
  logic        illegal_s;
  logic [31:0] wval_s;
  logic        take_irq_s;
  logic        trap_s;
  logic        mret_s;
  logic        csr_we_s;
  logic        mst_we_s;
  logic [31:0] trap_cause_s;
  logic [31:0] tvec_base_s;
  logic [31:0] trap_vector_s;
  logic        cyc_wlo_s;
  logic        cyc_whi_s;
  logic        ins_wlo_s;
  logic        ins_whi_s;
  logic [HPM_N-1:0] hpm_wlo_s;
  logic [HPM_N-1:0] hpm_whi_s;

  function automatic logic [31:0] cnt_hi(input logic [CNT_W-1:0] c);
    return 32'(c >> 32);
  endfunction

  // Replace one 32-bit half of a counter, holding the other half.
  function automatic logic [CNT_W-1:0] cnt_put(input logic [CNT_W-1:0] c, input logic hi,
                                               input logic [31:0] v);
    if (hi) begin
      return CNT_W'({v, c[31:0]});
    end else begin
      return {c[CNT_W-1:32], v};
    end
  endfunction

  // Bit 32 of the result flags an implemented address; unimplemented ones read 0.
  function automatic logic [32:0] csr_lookup(input logic [11:0] a);
    logic [32:0] r;
    r = {1'b1, 32'h0000_0000};
    case (a)
      12'h300: r[31:0] = mstatus_s;
      12'h301: r[31:0] = 32'h4010_0100;
      12'h304: r[31:0] = mie_r;
      12'h305: r[31:0] = mtvec_r;
      12'h310: r[31:0] = 32'h0000_0000;
      12'h340: r[31:0] = mscratch_r;
      12'h341: r[31:0] = mepc_r;
      12'h342: r[31:0] = mcause_r;
      12'h344: r[31:0] = mip_s;
      12'hF14: r[31:0] = 32'h0000_0000;
      12'hB00: r[31:0] = mcycle_r[31:0];
      12'hB80: r[31:0] = cnt_hi(mcycle_r);
      12'hB02: r[31:0] = minstret_r[31:0];
      12'hB82: r[31:0] = cnt_hi(minstret_r);
      default: begin
        r = {1'b0, 32'h0000_0000};
        for (int i = 0; i < NUM_HPM; i++) begin
          r = (a == 12'(32'hB03 + i)) ? {1'b1, hpm_cnt_r[i][31:0]} :
              (a == 12'(32'hB83 + i)) ? {1'b1, cnt_hi(hpm_cnt_r[i])} : r;
        end
      end
    endcase
    return r;
  endfunction

  assign mstatus_s = {19'h0, mst_mpp_r, 3'b000, mst_mpie_r, 3'b000, mst_mie_r, 3'b000};
  assign mip_s     = {20'h0, irq_s2_r[2], 3'b000, irq_s2_r[1], 3'b000, irq_s2_r[0], 3'b000};

  // Interrupt request and the highest-priority pending cause (MEI > MSI > MTI).
  always_comb begin
    pend_s        = mip_s & mie_r;
    gie_s         = (priv_r == PRIV_U) ? 1'b1 : mst_mie_r;
    irq_pending_s = gie_s && (|pend_s);
    if (pend_s[11]) begin
      irq_code_s = 4'd11;
    end else if (pend_s[3]) begin
      irq_code_s = 4'd3;
    end else begin
      irq_code_s = 4'd7;
    end
  end

  // Address decode and read-modify-write value for the committed CSR op.
  always_comb begin
    rlook_s   = csr_lookup(csr.raddr);
    wlook_s   = csr_lookup(csr.waddr);
    wro_s     = (csr.waddr == 12'h301) || (csr.waddr == 12'hF14);
    illegal_s = !rlook_s[32] || (csr.wenable && (!wlook_s[32] || wro_s));
    case (csr.csr_op)
      2'b01:   wval_s = csr.wsrc;
      2'b10:   wval_s = wlook_s[31:0] | csr.wsrc;
      2'b11:   wval_s = wlook_s[31:0] & ~csr.wsrc;
      default: wval_s = wlook_s[31:0];
    endcase
  end

  // Event arbitration: exception > interrupt > mret > CSR write.
  always_comb begin
    take_irq_s   = irq_accept_w && irq_pending_s && !exception_w;
    trap_s       = exception_w || take_irq_s;
    mret_s       = mret_w && !trap_s;
    csr_we_s     = csr.wenable && !illegal_s && (csr.csr_op != 2'b00) && !trap_s;
    mst_we_s     = csr_we_s && (csr.waddr == 12'h300) && !mret_s;
    trap_cause_s = exception_w ? {28'h0, exc_cause_w} : {1'b1, 27'h0, irq_code_s};
    tvec_base_s  = mtvec_r & 32'hFFFF_FFFC;
    if (take_irq_s && mtvec_r[0]) begin
      trap_vector_s = tvec_base_s + {26'h0, irq_code_s, 2'b00};
    end else begin
      trap_vector_s = tvec_base_s;
    end
  end

  // Counter-half write strobes.
  always_comb begin
    cyc_wlo_s = csr_we_s && (csr.waddr == 12'hB00);
    cyc_whi_s = csr_we_s && (csr.waddr == 12'hB80);
    ins_wlo_s = csr_we_s && (csr.waddr == 12'hB02);
    ins_whi_s = csr_we_s && (csr.waddr == 12'hB82);
    hpm_wlo_s = {HPM_N{1'b0}};
    hpm_whi_s = {HPM_N{1'b0}};
    for (int i = 0; i < HPM_N; i++) begin
      hpm_wlo_s[i] = csr_we_s && (csr.waddr == 12'(32'hB03 + i));
      hpm_whi_s[i] = csr_we_s && (csr.waddr == 12'(32'hB83 + i));
    end
  end

  // Trap, mret and CSR-write state, plus the interrupt synchroniser.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      priv_r     <= PRIV_M;
      mst_mie_r  <= 1'b0;
      mst_mpie_r <= 1'b0;
      mst_mpp_r  <= PRIV_M;
      mie_r      <= 32'h0000_0000;
      mtvec_r    <= 32'h0000_0000;
      mscratch_r <= 32'h0000_0000;
      mepc_r     <= 32'h0000_0000;
      mcause_r   <= 32'h0000_0000;
      irq_s1_r   <= 3'b000;
      irq_s2_r   <= 3'b000;
    end else begin
      irq_s1_r <= {irq_ext, irq_timer, irq_sw};
      irq_s2_r <= irq_s1_r;
      if (trap_s) begin
        mepc_r     <= pc_w & 32'hFFFF_FFFC;
        mst_mpie_r <= mst_mie_r;
        mst_mie_r  <= 1'b0;
        mst_mpp_r  <= priv_r;
        priv_r     <= PRIV_M;
        mcause_r   <= trap_cause_s;
      end else if (mret_s) begin
        mst_mie_r  <= mst_mpie_r;
        mst_mpie_r <= 1'b1;
        priv_r     <= mst_mpp_r;
        mst_mpp_r  <= PRIV_U;
      end else if (mst_we_s) begin
        mst_mie_r  <= wval_s[3];
        mst_mpie_r <= wval_s[7];
        mst_mpp_r  <= (wval_s[12:11] == PRIV_M) ? PRIV_M : PRIV_U;
      end
      if (csr_we_s) begin
        case (csr.waddr)
          12'h304: mie_r      <= wval_s & 32'h0000_0888;
          12'h305: mtvec_r    <= wval_s & ((VECTORED != 0) ? 32'hFFFF_FFFD : 32'hFFFF_FFFC);
          12'h340: mscratch_r <= wval_s;
          12'h341: mepc_r     <= wval_s & 32'hFFFF_FFFC;
          12'h342: mcause_r   <= wval_s;
          default: ;
        endcase
      end
    end
  end

  // A software write to a counter half takes the place of that cycle's increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcycle_r   <= CNT_ZERO;
      minstret_r <= CNT_ZERO;
    end else begin
      if (cyc_wlo_s || cyc_whi_s) begin
        mcycle_r <= cnt_put(mcycle_r, cyc_whi_s, wval_s);
      end else begin
        mcycle_r <= mcycle_r + CNT_ONE;
      end
      if (ins_wlo_s || ins_whi_s) begin
        minstret_r <= cnt_put(minstret_r, ins_whi_s, wval_s);
      end else if (retire_w && !exception_w) begin
        minstret_r <= minstret_r + CNT_ONE;
      end
    end
  end

  // Performance counters; slots beyond NUM_HPM stay zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < HPM_N; i++) begin
      if (!rst_n || (i >= NUM_HPM)) begin
        hpm_cnt_r[i] <= CNT_ZERO;
      end else if (hpm_wlo_s[i] || hpm_whi_s[i]) begin
        hpm_cnt_r[i] <= cnt_put(hpm_cnt_r[i], hpm_whi_s[i], wval_s);
      end else if (hpm_event[i]) begin
        hpm_cnt_r[i] <= hpm_cnt_r[i] + CNT_ONE;
      end
    end
  end

  assign csr.rdata          = rlook_s[31:0];
  assign csr.illegal_access = illegal_s;
  assign irq_pending        = irq_pending_s;
  assign trap_vector        = trap_vector_s;
  assign mepc               = mepc_r;
  assign priv               = priv_r;

endmodule

// File: doc/cpu_csr_unit.md
# cpu_csr_unit

Parametrised machine-mode CSR unit for the pipelined RV32 core, sitting beside the writeback stage. It holds the trap, counter and interrupt state. It applies CSRRW/CSRRS/CSRRC updates, takes synchronous exceptions and external/timer/software interrupts, and executes `mret`. Relative to the previous CSR file it adds:
- interrupt handling with MIE/MPIE stacking;
- vectored `mtvec`;
- configurable hardware performance counters;
- illegal-access flagging.

## Interface
Parameters:
- `NUM_HPM`, default 4: number of `mhpmcounterN`/`mhpmcounterNh` pairs, N = 3..3+NUM_HPM-1. Legal range 0..8.
- `CNT_W`, default 64: implemented counter width, 33..64. Bits above `CNT_W` read 0.
- `VECTORED`, default 1: when 1, `mtvec` mode 1 is honoured. When 0, `mtvec[1:0]` is forced to 0.

Ports (clock and reset first):
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `raddr`, in, 12: CSR read address.
- `rdata`, out, 32: combinational read data of current state.
- `csr_op`, in, 2: 01 write, 10 set, 11 clear, 00 none.
- `waddr`, in, 12: CSR write address.
- `wsrc`, in, 32: rs1/uimm operand.
- `wenable`, in, 1: commit the CSR op this cycle.
- `illegal_access`, out, 1: combinational. `raddr` unimplemented, or `wenable` with `waddr` read-only/unimplemented.
- `retire_w`, in, 1: an instruction retires in writeback.
- `exception_w`, in, 1: exception in writeback.
- `exc_cause_w`, in, 4: mcause code for the exception.
- `irq_accept_w`, in, 1: pipeline takes the pending interrupt at writeback.
- `mret_w`, in, 1: `mret` in writeback.
- `pc_w`, in, 32: writeback PC.
- `irq_ext`, in, 1: async external interrupt level.
- `irq_timer`, in, 1: async timer interrupt level.
- `irq_sw`, in, 1: async software interrupt level.
- `hpm_event`, in, max(NUM_HPM,1): per-counter increment strobes.
- `irq_pending`, out, 1: interrupt request to the pipeline.
- `trap_vector`, out, 32: redirect target on trap.
- `mepc`, out, 32: return target for `mret`.
- `priv`, out, 2: current privilege, 11 = M, 00 = U.

## Operation
- Implemented CSRs: `mstatus`, `mstatush` (all 0), `misa` (RO, 0x40100100), `mhartid` (RO, 0), `mie`, `mtvec`, `mscratch`, `mepc`, `mcause`, `mip`, `mcycle[h]`, `minstret[h]`, `mhpmcounter[h]`.
- Any other address sets `illegal_access` and returns `rdata` 0.
- Write value is computed from the old value: `wsrc`, `old|wsrc`, or `old&~wsrc`. The update applies only when `wenable && !illegal_access`.
- `mstatus` implements only MIE[3], MPIE[7] and MPP[12:11]. All other bits read 0.
- MPP is WARL: a written value other than 11 is stored as 00.
- `mie` implements bits 3, 7 and 11.
- `mip` bits are read-only and reflect the interrupt inputs after a 2-flop synchroniser: MEIP[11], MTIP[7], MSIP[3]. Writes to `mip` are ignored (not illegal).
- `mepc[1:0]` always reads 0.
- `irq_pending` = `mstatus.MIE && |(mip & mie)`. In U-mode, global MIE is treated as 1.
- Interrupt priority is MEI > MSI > MTI.
- Trap entry occurs on `exception_w` or `irq_accept_w`. On entry:
  - `mepc` ← `pc_w`;
  - MPIE ← MIE, MIE ← 0;
  - MPP ← `priv`, `priv` ← M;
  - `mcause` ← `{0, exc_cause_w}` for an exception, or `{1, code}` (11/3/7) for an interrupt.
- `irq_accept_w` is ignored when `irq_pending` = 0.
- `trap_vector` = `{mtvec[31:2],2'b00}`. When the mode is 1 and the trap is an interrupt, it is that base + 4·code.
- `mret`: MIE ← MPIE, MPIE ← 1, `priv` ← MPP, MPP ← 00.
- Priority within a cycle: exception > interrupt > `mret` > CSR write.
  - A trap suppresses a simultaneous CSR write and `mret`.
  - `mret` suppresses a simultaneous CSR write only on `mstatus`.
- Counters:
  - `mcycle` increments every cycle.
  - `minstret` increments on `retire_w && !exception_w`.
  - Each `mhpmcounterN` increments on `hpm_event[N-3]`.
  - All counters wrap at 2^CNT_W.
  - A CSR write to either half of a counter replaces that half with the written value, with no increment in that cycle. The other half is held.
- CSR accesses in U-mode are not checked here; decode raises the illegal-instruction exception.

## Timing
- All state updates on posedge `clk`. Writes and traps are visible on `rdata` the next cycle.
- `trap_vector` and `illegal_access` are combinational from current state and inputs.
- `irq_pending` lags an interrupt input by 2 cycles (synchroniser) and is combinational thereafter.
- Reset values: `priv` = M; `mstatus` = MPP 11, MIE 0, MPIE 0; `mie`, `mtvec`, `mscratch`, `mepc`, `mcause` = 0; all counters = 0; synchroniser flops = 0.
- Resulting output values at reset: `rdata` per address, `irq_pending` = 0, `trap_vector` = 0, `mepc` = 0, `priv` = 11.
- Reset asserted mid-operation overrides every pending event in that cycle.

## Test plan
- Reset, then read `mcycle` at cycles 0, 5 → 0, 5. Write `mcycle` = 0xFFFFFFFF, wait 1 cycle → `mcycleh` = 1, `mcycle` = 0.
- CSRRS `mie` with 0x888, then CSRRC with 0x080 → `mie` = 0x808. Write to 0x7C0 → `illegal_access` = 1, state unchanged.
- Set MIE, `mie` = 0x80, raise `irq_timer` → `irq_pending` high after 2 cycles. `irq_accept_w` at `pc_w` = 0x100 with `mtvec` = 0x1001 → `trap_vector` = 0x101C, `mcause` = 0x80000007, `mepc` = 0x100, MIE = 0, MPIE = 1.
- `exception_w` with cause 2, same cycle as `wenable` to `mscratch` → `mcause` = 2, `mscratch` unchanged, `priv` = M.
- Write MPP = 00, then `mret_w` → `priv` = 00, MIE = old MPIE, MPIE = 1. A following `exception_w` → MPP = 00, `priv` = 11.
- `NUM_HPM` = 2, `CNT_W` = 40: pulse `hpm_event[1]` 3 times → `mhpmcounter4` = 3. Preload 0xFF_FFFFFFFF, pulse 1 → counter wraps to 0.
